// File: rtl/rs_pkg.sv
// Shared types and helpers for the multi-entry reservation station.
package rs_pkg;

  localparam int NUM_FU_DEFAULT = 4;
  localparam int CDB_N_DEFAULT  = 2;
  localparam int PREG_W_DEFAULT = 6;
  localparam int PKT_W_DEFAULT  = 64;

  // Functional-unit classes; the value is the issue-port index.
  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_LD   = 2'd1,
    FU_ST   = 2'd2,
    FU_MULT = 2'd3
  } fu_class_e;

  // One station entry in the default configuration.
  typedef struct packed {
    logic                      busy;
    fu_class_e                 fu;
    logic [PREG_W_DEFAULT-1:0] t;
    logic [PREG_W_DEFAULT-1:0] t1;
    logic [PREG_W_DEFAULT-1:0] t2;
    logic                      t1_ready;
    logic                      t2_ready;
    logic [PKT_W_DEFAULT-1:0]  pkt;
  } rs_entry_t;

  // True when any valid CDB port broadcasts the given tag.
  function automatic logic tag_match(
    input logic [PREG_W_DEFAULT-1:0]               tag,
    input logic [CDB_N_DEFAULT-1:0]                cdb_valid,
    input logic [CDB_N_DEFAULT*PREG_W_DEFAULT-1:0] cdb_tag
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_N_DEFAULT; k++) begin
      if (cdb_valid[k] && (cdb_tag[k*PREG_W_DEFAULT +: PREG_W_DEFAULT] == tag)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-first picker: from an eligibility vector and the age matrix,
// return a one-hot vector marking the oldest eligible entry.
// age_i[j][i] = 1 means entry j is older than entry i.
module rs_age_select import rs_pkg::*; #(
  parameter int RS_DEPTH = 8
) (
  input  logic [RS_DEPTH-1:0] age_i [RS_DEPTH],
  input  logic [RS_DEPTH-1:0] elig_i,
  output logic [RS_DEPTH-1:0] grant_o
);

  logic [RS_DEPTH-1:0] older;

  // An eligible entry wins when no other eligible entry is older than it.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // update, so no path leaves a value held and no latch is inferred.
    // NOTE: combinational logic uses blocking '=' so later statements see the
    // updated value; clocked state elsewhere uses non-blocking '<='.
    older   = '0;
    grant_o = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        if ((j != i) && elig_i[j] && age_i[j][i]) begin
          older[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      grant_o[i] = elig_i[i] & ~older[i];
    end
  end

endmodule

// File: rtl/rs_multi.sv
// Multi-entry reservation station: shared slots, CDB wakeup, age-ordered
// select per FU class, squash. Sits between rename/dispatch and the FUs.
module rs_multi import rs_pkg::*; #(
  parameter  int RS_DEPTH = 8,
  parameter  int NUM_FU   = NUM_FU_DEFAULT,
  parameter  int CDB_N    = CDB_N_DEFAULT,
  parameter  int PREG_W   = PREG_W_DEFAULT,
  parameter  int PKT_W    = PKT_W_DEFAULT,
  localparam int FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int IDX_W    = $clog2(RS_DEPTH),
  localparam int CNT_W    = $clog2(RS_DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  logic [FU_W-1:0]          dispatch_fu,
  input  logic [PREG_W-1:0]        dispatch_t,
  input  logic [PREG_W-1:0]        dispatch_t1,
  input  logic [PREG_W-1:0]        dispatch_t2,
  input  logic                     dispatch_t1_used,
  input  logic                     dispatch_t2_used,
  input  logic                     dispatch_t1_ready,
  input  logic                     dispatch_t2_ready,
  input  logic [PKT_W-1:0]         dispatch_pkt,
  input  logic [CDB_N-1:0]         cdb_valid,
  input  logic [CDB_N*PREG_W-1:0]  cdb_tag,
  input  logic [NUM_FU-1:0]        fu_ready,
  output logic [NUM_FU-1:0]        issue_valid,
  output logic [NUM_FU*PKT_W-1:0]  issue_pkt,
  output logic [NUM_FU*PREG_W-1:0] issue_t,
  output logic [CNT_W-1:0]         free_count
);

  // Control state (reset)
  logic [RS_DEPTH-1:0] busy_q, busy_d;
  logic [RS_DEPTH-1:0] age_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] age_d [RS_DEPTH];

  // Entry contents (no reset; only meaningful while busy)
  logic [FU_W-1:0]     fu_q  [RS_DEPTH];
  logic [PREG_W-1:0]   t_q   [RS_DEPTH];
  logic [PREG_W-1:0]   t1_q  [RS_DEPTH];
  logic [PREG_W-1:0]   t2_q  [RS_DEPTH];
  logic [PKT_W-1:0]    pkt_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] r1_q, r2_q;

  logic [RS_DEPTH-1:0] hit1, hit2;
  logic                disp_hit1, disp_hit2;
  logic                src1_rdy, src2_rdy;
  logic [IDX_W-1:0]    alloc_idx;
  logic                fu_ok;
  logic                alloc_fire;
  logic [RS_DEPTH-1:0] elig;
  logic [RS_DEPTH-1:0] elig_fu [NUM_FU];
  logic [RS_DEPTH-1:0] grant   [NUM_FU];
  logic [RS_DEPTH-1:0] issued_mask;

  // Classes that cannot be encoded in dispatch_fu's width need no range check.
  if ((1 << FU_W) > NUM_FU) begin : g_fu_chk
    assign fu_ok = ({1'b0, dispatch_fu} < (FU_W + 1)'(NUM_FU));
    a_fu_range: assert property (@(posedge clock) disable iff (reset)
      dispatch_valid |-> fu_ok);
  end else begin : g_fu_all
    assign fu_ok = 1'b1;
  end

  // Free-slot status and count come from registered busy bits only.
  assign dispatch_ready = |(~busy_q);
  assign alloc_fire     = dispatch_valid && dispatch_ready && !squash && fu_ok;

  // Occupancy: count of clear busy bits.
  always_comb begin
    free_count = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!busy_q[i]) free_count = free_count + CNT_W'(1);
    end
  end

  // Lowest-index free slot receives the next dispatch.
  always_comb begin
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  // CDB tag compare for stored sources and for the incoming dispatch.
  always_comb begin
    hit1      = '0;
    hit2      = '0;
    disp_hit1 = 1'b0;
    disp_hit2 = 1'b0;
    for (int k = 0; k < CDB_N; k++) begin
      if (cdb_valid[k]) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (cdb_tag[k*PREG_W +: PREG_W] == t1_q[i]) hit1[i] = 1'b1;
          if (cdb_tag[k*PREG_W +: PREG_W] == t2_q[i]) hit2[i] = 1'b1;
        end
        if (cdb_tag[k*PREG_W +: PREG_W] == dispatch_t1) disp_hit1 = 1'b1;
        if (cdb_tag[k*PREG_W +: PREG_W] == dispatch_t2) disp_hit2 = 1'b1;
      end
    end
  end

  // A source is ready at allocation if unused, already available, or bypassed.
  assign src1_rdy = !dispatch_t1_used || dispatch_t1_ready || disp_hit1;
  assign src2_rdy = !dispatch_t2_used || dispatch_t2_ready || disp_hit2;

  // Eligibility from registered state; split per FU class.
  assign elig = busy_q & r1_q & r2_q;

  for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
    always_comb begin
      elig_fu[f] = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        elig_fu[f][i] = elig[i] && (fu_q[i] == FU_W'(f));
      end
    end

    rs_age_select #(.RS_DEPTH(RS_DEPTH)) u_age_select (
      .age_i   (age_q),
      .elig_i  (elig_fu[f]),
      .grant_o (grant[f])
    );
  end

  // Issue mux: drive the granted entry per class, zero when nothing issues.
  always_comb begin
    issue_valid = '0;
    issue_pkt   = '0;
    issue_t     = '0;
    issued_mask = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      issue_valid[f] = fu_ready[f] && (|elig_fu[f]);
      if (issue_valid[f]) begin
        issued_mask = issued_mask | grant[f];
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (grant[f][i]) begin
            issue_pkt[f*PKT_W +: PKT_W]   = pkt_q[i];
            issue_t[f*PREG_W +: PREG_W]   = t_q[i];
          end
        end
      end
    end
  end

  // Busy next state: free issued slots, claim the allocated slot; squash wins.
  always_comb begin
    busy_d = busy_q & ~issued_mask;
    if (alloc_fire) busy_d[alloc_idx] = 1'b1;
    if (squash)     busy_d = '0;
  end

  // Age next state: new entry is younger than every entry that stays busy.
  always_comb begin
    age_d = age_q;
    if (alloc_fire) begin
      age_d[alloc_idx] = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy_q[i] && !issued_mask[i]) age_d[i][alloc_idx] = 1'b1;
      end
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) age_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      age_q  <= age_d;
    end
  end

  // Entry contents: wakeup on CDB match, overwrite on allocation.
  // NOTE: entry payload/tags are deliberately not reset; they are only read
  // while the busy bit is set, and issue outputs are gated to zero otherwise.
  always_ff @(posedge clock) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      r1_q[i] <= r1_q[i] | hit1[i];
      r2_q[i] <= r2_q[i] | hit2[i];
    end
    if (alloc_fire) begin
      fu_q[alloc_idx]  <= dispatch_fu;
      t_q[alloc_idx]   <= dispatch_t;
      t1_q[alloc_idx]  <= dispatch_t1;
      t2_q[alloc_idx]  <= dispatch_t2;
      pkt_q[alloc_idx] <= dispatch_pkt;
      r1_q[alloc_idx]  <= src1_rdy;
      r2_q[alloc_idx]  <= src2_rdy;
    end
  end

endmodule

// File: tb/tb_rs_multi.sv
// Self-checking bench for rs_multi: directed scenarios plus random traffic,
// compared every cycle against an age-ordered queue model.
module tb_rs_multi;
  import rs_pkg::*;

  localparam int RS_DEPTH = 8;
  localparam int NUM_FU   = 4;
  localparam int CDB_N    = 2;
  localparam int PREG_W   = 6;
  localparam int PKT_W    = 64;

  logic                     clock;
  logic                     reset;
  logic                     squash;
  logic                     dispatch_valid;
  logic                     dispatch_ready;
  logic [1:0]               dispatch_fu;
  logic [PREG_W-1:0]        dispatch_t, dispatch_t1, dispatch_t2;
  logic                     dispatch_t1_used, dispatch_t2_used;
  logic                     dispatch_t1_ready, dispatch_t2_ready;
  logic [PKT_W-1:0]         dispatch_pkt;
  logic [CDB_N-1:0]         cdb_valid;
  logic [CDB_N*PREG_W-1:0]  cdb_tag;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU-1:0]        issue_valid;
  logic [NUM_FU*PKT_W-1:0]  issue_pkt;
  logic [NUM_FU*PREG_W-1:0] issue_t;
  logic [3:0]               free_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: live entries in allocation order, oldest first.
  rs_entry_t ent[$];

  rs_multi #(
    .RS_DEPTH(RS_DEPTH), .NUM_FU(NUM_FU), .CDB_N(CDB_N),
    .PREG_W(PREG_W), .PKT_W(PKT_W)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .squash            (squash),
    .dispatch_valid    (dispatch_valid),
    .dispatch_ready    (dispatch_ready),
    .dispatch_fu       (dispatch_fu),
    .dispatch_t        (dispatch_t),
    .dispatch_t1       (dispatch_t1),
    .dispatch_t2       (dispatch_t2),
    .dispatch_t1_used  (dispatch_t1_used),
    .dispatch_t2_used  (dispatch_t2_used),
    .dispatch_t1_ready (dispatch_t1_ready),
    .dispatch_t2_ready (dispatch_t2_ready),
    .dispatch_pkt      (dispatch_pkt),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .fu_ready          (fu_ready),
    .issue_valid       (issue_valid),
    .issue_pkt         (issue_pkt),
    .issue_t           (issue_t),
    .free_count        (free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Oldest ready entry of class f in the model, or -1 (also -1 if FU busy).
  function automatic int pick(input int f);
    if (!fu_ready[f]) return -1;
    foreach (ent[i]) begin
      if (int'(ent[i].fu) == f && ent[i].t1_ready && ent[i].t2_ready) return i;
    end
    return -1;
  endfunction

  task automatic compare_model();
    logic [NUM_FU-1:0]        ev;
    logic [NUM_FU*PREG_W-1:0] et;
    logic [NUM_FU*PKT_W-1:0]  ep;
    int p;
    ev = '0; et = '0; ep = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      p = pick(f);
      if (p >= 0) begin
        ev[f] = 1'b1;
        et[f*PREG_W +: PREG_W] = ent[p].t;
        ep[f*PKT_W +: PKT_W]   = ent[p].pkt;
      end
    end
    check("issue_valid", 256'(issue_valid), 256'(ev));
    check("issue_t", 256'(issue_t), 256'(et));
    check("issue_pkt", 256'(issue_pkt), 256'(ep));
    check("free_count", 256'(free_count), 256'(RS_DEPTH - ent.size()));
    check("dispatch_ready", 256'(dispatch_ready), 256'(ent.size() < RS_DEPTH));
  endtask

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_step();
    rs_entry_t nq[$];
    rs_entry_t e;
    bit        gone [RS_DEPTH];
    int        p;
    int        n_before;
    if (reset || squash) begin
      ent.delete();
      return;
    end
    n_before = ent.size();
    foreach (gone[i]) gone[i] = 1'b0;
    for (int f = 0; f < NUM_FU; f++) begin
      p = pick(f);
      if (p >= 0) gone[p] = 1'b1;
    end
    foreach (ent[i]) begin
      if (!gone[i]) begin
        e = ent[i];
        e.t1_ready = e.t1_ready | tag_match(e.t1, cdb_valid, cdb_tag);
        e.t2_ready = e.t2_ready | tag_match(e.t2, cdb_valid, cdb_tag);
        nq.push_back(e);
      end
    end
    if (dispatch_valid && n_before < RS_DEPTH) begin
      e.busy     = 1'b1;
      e.fu       = fu_class_e'(dispatch_fu);
      e.t        = dispatch_t;
      e.t1       = dispatch_t1;
      e.t2       = dispatch_t2;
      e.t1_ready = !dispatch_t1_used || dispatch_t1_ready || tag_match(dispatch_t1, cdb_valid, cdb_tag);
      e.t2_ready = !dispatch_t2_used || dispatch_t2_ready || tag_match(dispatch_t2, cdb_valid, cdb_tag);
      e.pkt      = dispatch_pkt;
      nq.push_back(e);
    end
    ent = nq;
  endtask

  // One cycle: compare at the falling edge, advance model at the rising edge.
  task automatic cycle();
    @(negedge clock);
    compare_model();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = '0;
    cdb_tag        = '0;
    squash         = 1'b0;
  endtask

  task automatic drive_disp(input int fu, input int t,
                            input int t1, input bit u1, input bit r1,
                            input int t2, input bit u2, input bit r2);
    dispatch_valid    = 1'b1;
    dispatch_fu       = 2'(fu);
    dispatch_t        = PREG_W'(t);
    dispatch_t1       = PREG_W'(t1);
    dispatch_t1_used  = u1;
    dispatch_t1_ready = r1;
    dispatch_t2       = PREG_W'(t2);
    dispatch_t2_used  = u2;
    dispatch_t2_ready = r2;
    dispatch_pkt      = {$urandom, $urandom};
  endtask

  task automatic rand_inputs();
    dispatch_valid    = ($urandom_range(0, 9) < 6);
    dispatch_fu       = 2'($urandom_range(0, 3));
    dispatch_t        = PREG_W'($urandom);
    dispatch_t1       = PREG_W'($urandom_range(0, 15));
    dispatch_t2       = PREG_W'($urandom_range(0, 15));
    dispatch_t1_used  = 1'($urandom);
    dispatch_t2_used  = 1'($urandom);
    dispatch_t1_ready = ($urandom_range(0, 9) < 3);
    dispatch_t2_ready = ($urandom_range(0, 9) < 3);
    dispatch_pkt      = {$urandom, $urandom};
    cdb_valid         = CDB_N'($urandom);
    cdb_tag           = {PREG_W'($urandom_range(0, 15)), PREG_W'($urandom_range(0, 15))};
    fu_ready          = NUM_FU'($urandom);
    squash            = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    drive_disp(0, 0, 0, 0, 0, 0, 0, 0);
    dispatch_valid = 1'b0;
    fu_ready = '1;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_free_count", 256'(free_count), 256'(8));
    check("rst_dispatch_ready", 256'(dispatch_ready), 256'(1));
    check("rst_issue_valid", 256'(issue_valid), 256'(0));
    check("rst_issue_pkt", 256'(issue_pkt), 256'(0));
    reset = 1'b0;
    cycle();

    // ALU op waits on tag 5, broadcast two cycles after dispatch
    drive_disp(FU_ALU, 20, 5, 1, 0, 0, 0, 0);
    cycle();
    idle();
    cycle();
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd5};
    #1 check("wake_not_yet", 256'(issue_valid[0]), 256'(0));
    cycle();
    idle();
    #1 check("wake_issue_valid", 256'(issue_valid[0]), 256'(1));
    check("wake_issue_t", 256'(issue_t[5:0]), 256'(20));
    cycle();

    // Three ready LD ops held by a busy LD unit, then issued in age order
    fu_ready = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      drive_disp(FU_LD, 10 + k, 0, 0, 0, 0, 0, 0);
      cycle();
    end
    idle();
    fu_ready = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1 check("ld_order_t", 256'(issue_t[11:6]), 256'(10 + k));
      check("ld_order_free", 256'(free_count), 256'(5 + k));
      cycle();
    end
    #1 check("ld_done_free", 256'(free_count), 256'(8));

    // Fill with unready MULT ops, attempt an extra dispatch, wake one entry
    for (int k = 0; k < 8; k++) begin
      drive_disp(FU_MULT, 40 + k, 30 + k, 1, 0, 0, 0, 0);
      cycle();
    end
    idle();
    #1 check("full_dispatch_ready", 256'(dispatch_ready), 256'(0));
    check("full_free_count", 256'(free_count), 256'(0));
    drive_disp(FU_ALU, 7, 0, 0, 0, 0, 0, 0);
    cycle();
    idle();
    #1 check("full_drop_alu", 256'(issue_valid[0]), 256'(0));
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd33};
    cycle();
    idle();
    #1 check("full_wake_issue", 256'(issue_valid[3]), 256'(1));
    check("full_wake_t", 256'(issue_t[23:18]), 256'(43));
    check("full_ready_same_cycle", 256'(dispatch_ready), 256'(0));
    cycle();
    #1 check("full_ready_next_cycle", 256'(dispatch_ready), 256'(1));
    check("full_free_after", 256'(free_count), 256'(1));
    cycle();
    squash = 1'b1;
    cycle();
    idle();

    // Same-cycle CDB bypass on source 2
    drive_disp(FU_ST, 50, 0, 0, 0, 9, 1, 0);
    cdb_valid = 2'b10;
    cdb_tag   = {6'd9, 6'd0};
    cycle();
    idle();
    #1 check("bypass_issue", 256'(issue_valid[2]), 256'(1));
    check("bypass_t", 256'(issue_t[17:12]), 256'(50));
    cycle();

    // Squash with four busy entries and a concurrent dispatch
    for (int k = 0; k < 4; k++) begin
      drive_disp(FU_ALU, 1 + k, 40 + k, 1, 0, 0, 0, 0);
      cycle();
    end
    idle();
    squash = 1'b1;
    drive_disp(FU_ALU, 60, 0, 0, 0, 0, 0, 0);
    #1 check("squash_before", 256'(free_count), 256'(4));
    cycle();
    idle();
    #1 check("squash_free", 256'(free_count), 256'(8));
    check("squash_issue", 256'(issue_valid), 256'(0));
    cycle();

    // Random traffic, an asynchronous reset in the middle, more traffic
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      cycle();
    end
    reset = 1'b1;
    ent.delete();
    #1 check("async_rst_free", 256'(free_count), 256'(8));
    check("async_rst_issue", 256'(issue_valid), 256'(0));
    cycle();
    reset = 1'b0;
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rs_multi.md
Name: rs_multi

Overview:
- Parametrised, multi-entry reservation station for the out-of-order core.
- Sits between dispatch (after rename) and the functional units.
- Each entry holds one renamed instruction, its destination tag and two source tags. Entries wake up on CDB broadcasts.
- Per cycle, issues the oldest ready entry to each FU class whose unit is ready.
- Replaces the fixed one-slot-per-FU station with N shared slots, multiple CDB ports, age-ordered select and squash.

Parameters:
- RS_DEPTH, 8, number of entries (≥2).
- NUM_FU, 4, number of FU classes (0=ALU, 1=LD, 2=ST, 3=MULT).
- CDB_N, 2, number of CDB broadcast ports.
- PREG_W, 6, physical tag width.
- PKT_W, 64, opaque instruction payload width, carried untouched.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- squash  in  1  flush all entries (mispredict).
- dispatch_valid  in  1  dispatch request.
- dispatch_ready  out  1  at least one free entry.
- dispatch_fu  in  clog2(NUM_FU)  target FU class.
- dispatch_t  in  PREG_W  destination tag.
- dispatch_t1 / dispatch_t2  in  PREG_W  source tags.
- dispatch_t1_used / dispatch_t2_used  in  1  source is read.
- dispatch_t1_ready / dispatch_t2_ready  in  1  source value already available.
- dispatch_pkt  in  PKT_W  payload.
- cdb_valid  in  CDB_N  per-port broadcast valid.
- cdb_tag  in  CDB_N*PREG_W  per-port broadcast tag.
- fu_ready  in  NUM_FU  FU class can accept this cycle.
- issue_valid  out  NUM_FU  issue per class.
- issue_pkt  out  NUM_FU*PKT_W  issued payload per class.
- issue_t  out  NUM_FU*PREG_W  issued destination tag per class.
- free_count  out  clog2(RS_DEPTH+1)  number of free entries.

Behaviour:
- Reset (async, active-high): all busy bits = 0; age matrix = 0.
  - Outputs: issue_valid = 0, dispatch_ready = 1, free_count = RS_DEPTH; all payload outputs = 0.
- Dispatch:
  - Accepted on a rising edge when dispatch_valid && dispatch_ready && !squash.
  - Writes the lowest-index free entry, which becomes busy at that edge.
  - dispatch_ready = |~busy, computed from registered state only. A slot freed by issue in cycle N is reusable in cycle N+1, not N.
- Source ready bit at allocation:
  - set if srcX_used == 0, or srcX_ready == 1, or any cdb_valid[k] with cdb_tag[k] == srcX in the same cycle (same-cycle CDB bypass).
- Wakeup:
  - Every busy entry compares both source tags against all CDB ports each cycle. A match sets the ready bit at the edge.
  - An unused source never matches and stays ready.
- Eligibility: busy && t1_ready && t2_ready, evaluated on registered state.
  - An entry woken at the edge ending cycle N is eligible in cycle N+1.
  - A newly dispatched entry is eligible no earlier than the cycle after allocation.
- Select, per FU class f, combinational:
  - issue_valid[f] = fu_ready[f] && (any eligible entry with fu == f).
  - Chosen entry is the oldest per the age matrix.
  - issue_pkt/issue_t[f] carry that entry; when issue_valid[f] = 0 they are 0.
  - An entry is freed at the edge where its issue_valid && fu_ready hold.
  - Up to NUM_FU entries issue and free per cycle.
- Age matrix RS_DEPTH×RS_DEPTH:
  - On allocating entry k, set row k = 0 and column k = 1 for all currently busy entries.
  - Entry i is oldest in class f when no other eligible entry j in class f has age[j][i] = 1.
- free_count:
  - Next value = current − accepted dispatch + number of issued entries.
  - Simultaneous dispatch and issue must net correctly. Never exceeds RS_DEPTH and never underflows.
- Squash:
  - All busy bits clear at the next edge; squash has priority over dispatch and wakeup.
  - issue_valid is still driven from registered state in the squash cycle. Downstream FUs discard it.
- Out-of-range dispatch_fu (≥ NUM_FU): not allocated; flagged by a simulation assertion.
- Reset asserted mid-operation: all entries are dropped immediately, no partial issue.

Decomposition:
- rs_pkg holds:
  - FU class enum (ALU, LD, ST, MULT) and NUM_FU_DEFAULT;
  - rs_entry_t struct: busy, fu, t, t1, t2, t1_ready, t2_ready, pkt;
  - helper function tag_match(tag, cdb_valid, cdb_tag).
- Natural sub-module: rs_age_select.
  - Given the age matrix and an eligibility vector, returns a one-hot oldest entry.
  - Instantiated once per FU class.

Test Plan:
- Reset then idle → free_count = 8, dispatch_ready = 1, issue_valid = 0000.
- Dispatch ALU op, t1 = 5 not ready, t2 unused. cdb_tag[0] = 5 valid two cycles later → issue_valid[0] = 1 exactly one cycle after the broadcast, issue_t = dispatched tag.
- Dispatch three ready LD ops A, B, C in consecutive cycles with fu_ready[1] = 0, then raise fu_ready[1] → issue order A, B, C on consecutive cycles. free_count goes 5→6→7→8.
- Fill all 8 entries with unready MULT ops → dispatch_ready = 0; a dispatch attempt is dropped. Wake one entry → it issues, and dispatch_ready = 1 the following cycle, not the issue cycle.
- Dispatch with t2 = 9 while cdb_tag[1] = 9 valid in the same cycle → entry eligible the next cycle.
- Four busy entries, assert squash together with a dispatch → next cycle free_count = 8, no new entry, issue_valid = 0 afterwards.
